// File: rtl/bm_output_sink.sv
// Consumer end of the BondMachine output-port handshake: captures each published value into a
// small first-word-fall-through FIFO and presents it on a ready/valid stream.
// Optional macro BM_OUTPUT_SINK_DROP_EN: when full, acknowledge and discard instead of stalling,
// counting discarded values on drop_count.
module bm_output_sink #(
  parameter int WIDTH     = 1,
  parameter int DEPTH     = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clock_signal,
  input  logic                 reset_signal,
  input  logic [WIDTH-1:0]     i0,
  input  logic                 i0_valid,
  output logic                 i0_received,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef BM_OUTPUT_SINK_DROP_EN
  output logic [15:0]          drop_count,
`endif
  output logic [DEPTH_LOG:0]   level
);

  // Handshake semantics: the producer holds i0_valid until it sees i0_received, then drops it;
  // downstream, a word transfers on every rising edge where out_valid and out_ready are both high.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam logic [DEPTH_LOG:0]   LVL_FULL = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG:0]   LVL_ONE  = (DEPTH_LOG + 1)'(1);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);

  state_t                 state_q, state_d;
  logic [DEPTH_LOG-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG:0]     level_q, level_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic                   push;
  logic                   pop;
  logic                   full;

  // Fullness comes from the registered level, so a pop in the same cycle never frees a slot early.
  assign full      = (level_q == LVL_FULL);
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;

`ifdef BM_OUTPUT_SINK_DROP_EN
  logic        drop;
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
`ifdef BM_OUTPUT_SINK_DROP_EN
    drop    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i0_valid && !full) begin
          push    = 1'b1;
          state_d = ST_ACK;
        end
`ifdef BM_OUTPUT_SINK_DROP_EN
        else if (i0_valid) begin
          drop    = 1'b1;
          state_d = ST_ACK;
        end
`endif
      end
      ST_ACK: begin
        // One capture per valid episode: wait for the producer to withdraw valid.
        if (!i0_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

`ifdef BM_OUTPUT_SINK_DROP_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clock_signal) begin
    if (reset_signal) drop_cnt_q <= '0;
    else              drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

  always_ff @(posedge clock_signal) begin
    if (reset_signal) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clock_signal) begin
    if (!reset_signal && push) mem_q[wr_ptr_q] <= i0;
  end

  assign i0_received = (state_q == ST_ACK);
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level       = level_q;

endmodule

// File: tb/tb_bm_output_sink.sv
// Directed bench for bm_output_sink (WIDTH=4, DEPTH=4): handshake latency, backpressure,
// held-valid single capture, mid-handshake reset, push/pop wrap and optional drop mode.
module tb_bm_output_sink;

  logic       clk;
  logic       rst;
  logic [3:0] i0;
  logic       i0_valid;
  logic       i0_received;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
`ifdef BM_OUTPUT_SINK_DROP_EN
  logic [15:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  bm_output_sink #(.WIDTH(4), .DEPTH(4), .DEPTH_LOG(2)) dut (
    .clock_signal (clk),
    .reset_signal (rst),
    .i0           (i0),
    .i0_valid     (i0_valid),
    .i0_received  (i0_received),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef BM_OUTPUT_SINK_DROP_EN
    .drop_count   (drop_count),
`endif
    .level        (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Completes one producer handshake with out_ready held low.
  task automatic push_val(input logic [3:0] v);
    i0       = v;
    i0_valid = 1'b1;
    tick();
    chk("push_ack", {31'd0, i0_received}, 32'd1);
    i0_valid = 1'b0;
    tick();
  endtask

  // Drains with out_ready high, comparing against exp_q; answers a pending producer ack.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (exp_q.size() != 0 || i0_valid); c++) begin
      if (out_valid && exp_q.size() != 0) chk(tag, {28'd0, out_data}, {28'd0, exp_q.pop_front()});
      if (i0_received) i0_valid = 1'b0;
      tick();
    end
    chk({tag, "_done"}, exp_q.size(), 32'd0);
    chk({tag, "_level"}, {29'd0, level}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i0 = '0; i0_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_recv",  {31'd0, i0_received}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  {28'd0, out_data}, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
`ifdef BM_OUTPUT_SINK_DROP_EN
    chk("rst_drop", {16'd0, drop_count}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // 1: single write, immediate consumption
    out_ready = 1'b1; i0 = 4'd1; i0_valid = 1'b1;
    chk("t1_recv_pre", {31'd0, i0_received}, 32'd0);
    tick();
    chk("t1_recv",  {31'd0, i0_received}, 32'd1);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_data",  {28'd0, out_data}, 32'd1);
    chk("t1_level", {29'd0, level}, 32'd1);
    i0_valid = 1'b0;
    tick();
    chk("t1_recv_off",  {31'd0, i0_received}, 32'd0);
    chk("t1_valid_off", {31'd0, out_valid}, 32'd0);
    chk("t1_level_off", {29'd0, level}, 32'd0);
    out_ready = 1'b0;

    // 2: fill to full, fifth value meets a full FIFO
    push_val(4'd3); push_val(4'd5); push_val(4'd9); push_val(4'd12);
    chk("t2_full", {29'd0, level}, 32'd4);
    chk("t2_head", {28'd0, out_data}, 32'd3);
    exp_q = '{4'd3, 4'd5, 4'd9, 4'd12};
    i0 = 4'd7; i0_valid = 1'b1;
`ifdef BM_OUTPUT_SINK_DROP_EN
    tick();
    chk("t2_drop_ack", {31'd0, i0_received}, 32'd1);
    chk("t2_drop_cnt", {16'd0, drop_count}, 32'd1);
    chk("t2_drop_lvl", {29'd0, level}, 32'd4);
    i0_valid = 1'b0;
    tick();
`else
    tick(); tick(); tick();
    chk("t2_stall_recv",  {31'd0, i0_received}, 32'd0);
    chk("t2_stall_level", {29'd0, level}, 32'd4);
    exp_q.push_back(4'd7);
`endif
    drain("t2_drain");

    // 3: valid held 10 cycles with changing data -> one capture
    i0 = 4'd10; i0_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      i0 = 4'(11 + k);
    end
    chk("t3_recv",  {31'd0, i0_received}, 32'd1);
    chk("t3_level", {29'd0, level}, 32'd1);
    i0_valid = 1'b0;
    tick();
    chk("t3_recv_off", {31'd0, i0_received}, 32'd0);
    exp_q = '{4'd10};
    drain("t3_drain");

    // 4: reset while acknowledging with level 2
    push_val(4'd2);
    i0 = 4'd4; i0_valid = 1'b1;
    tick();
    chk("t4_in_ack", {31'd0, i0_received}, 32'd1);
    chk("t4_level2", {29'd0, level}, 32'd2);
    rst = 1'b1; i0_valid = 1'b0;
    tick();
    chk("t4_rst_recv",  {31'd0, i0_received}, 32'd0);
    chk("t4_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_rst_level", {29'd0, level}, 32'd0);
    rst = 1'b0;
    tick();
    push_val(4'd6);
    chk("t4_after_data", {28'd0, out_data}, 32'd6);
    exp_q = '{4'd6};
    drain("t4_drain");

    // 5: simultaneous push/pop at level 2 across pointer wrap
    push_val(4'd1); push_val(4'd2);
    exp_q = '{4'd1, 4'd2};
    for (int k = 0; k < 8; k++) begin
      i0 = 4'(3 + k); i0_valid = 1'b1; out_ready = 1'b1;
      chk("t5_order", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
      exp_q.push_back(4'(3 + k));
      tick();
      chk("t5_level", {29'd0, level}, 32'd2);
      i0_valid = 1'b0; out_ready = 1'b0;
      tick();
    end
    drain("t5_drain");

`ifdef BM_OUTPUT_SINK_DROP_EN
    // 6: drop mode, six values against a full FIFO
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push_val(4'd1); push_val(4'd2); push_val(4'd3); push_val(4'd4);
    for (int k = 0; k < 6; k++) push_val(4'(8 + k));
    chk("t6_drop_cnt", {16'd0, drop_count}, 32'd6);
    chk("t6_level", {29'd0, level}, 32'd4);
    exp_q = '{4'd1, 4'd2, 4'd3, 4'd4};
    drain("t6_drain");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
